// File: rtl/vga_timing_gen.sv
// VGA timing generator with run-time programmable segment lengths.
// Horizontal and vertical counters walk ACTIVE -> FRONTPORCH -> SYNC ->
// BACKPORCH. Outputs are a registered decode of the counters: one enable
// cycle of latency, and all outputs stay aligned with each other.
// New timing is staged in pending registers and swapped in on the last
// pixel of a frame, so a frame is never drawn with mixed timing.
//
// Handshake: there is no valid/ready pair. Every output moves only on a
// cycle with enable=1 (one pixel per enable); cfg_load is a one-cycle
// strobe that is accepted on every cycle, enable or not, and cfg_pending
// reports that a staged configuration is still waiting for a frame edge.
module vga_timing_gen #(
  parameter int H_W    = 12,
  parameter int V_W    = 11,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HPOL   = 1'b0,
  parameter bit VPOL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [H_W-1:0] cfg_h_act,
  input  logic [H_W-1:0] cfg_h_fp,
  input  logic [H_W-1:0] cfg_h_sync,
  input  logic [H_W-1:0] cfg_h_bp,
  input  logic [V_W-1:0] cfg_v_act,
  input  logic [V_W-1:0] cfg_v_fp,
  input  logic [V_W-1:0] cfg_v_sync,
  input  logic [V_W-1:0] cfg_v_bp,
  input  logic           cfg_hpol,
  input  logic           cfg_vpol,
  input  logic           cfg_load,
  output logic           cfg_pending,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           line_start,
  output logic           frame_start,
  output logic [1:0]     h_state,
  output logic [1:0]     v_state
);

  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FP     = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BP     = 2'd3
  } seg_t;

  localparam int HS = H_W + 2;
  localparam int VS = V_W + 2;

  // A zero-length segment would break the sequencing, so it becomes 1.
  function automatic logic [H_W-1:0] fix_h(input logic [H_W-1:0] v);
    return (v == '0) ? H_W'(1) : v;
  endfunction

  function automatic logic [V_W-1:0] fix_v(input logic [V_W-1:0] v);
    return (v == '0) ? V_W'(1) : v;
  endfunction

  // Active timing
  logic [H_W-1:0] h_act_r, h_fp_r, h_sync_r, h_bp_r;
  logic [V_W-1:0] v_act_r, v_fp_r, v_sync_r, v_bp_r;
  logic           hpol_r, vpol_r;
  // Pending timing
  logic [H_W-1:0] p_h_act, p_h_fp, p_h_sync, p_h_bp;
  logic [V_W-1:0] p_v_act, p_v_fp, p_v_sync, p_v_bp;
  logic           p_hpol, p_vpol;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  logic [HS-1:0] h_b1, h_b2, h_b3, h_tot;
  logic [VS-1:0] v_b1, v_b2, v_b3, v_tot;
  seg_t          h_seg, v_seg;
  logic          h_wrap, v_wrap, frame_wrap;

  // Segment boundaries and axis state decoded from the current counters.
  always_comb begin
    h_b1  = {2'b00, h_act_r};
    h_b2  = h_b1 + {2'b00, h_fp_r};
    h_b3  = h_b2 + {2'b00, h_sync_r};
    h_tot = h_b3 + {2'b00, h_bp_r};
    v_b1  = {2'b00, v_act_r};
    v_b2  = v_b1 + {2'b00, v_fp_r};
    v_b3  = v_b2 + {2'b00, v_sync_r};
    v_tot = v_b3 + {2'b00, v_bp_r};

    h_seg = SEG_BP;
    if ({2'b00, h_cnt} < h_b1)      h_seg = SEG_ACTIVE;
    else if ({2'b00, h_cnt} < h_b2) h_seg = SEG_FP;
    else if ({2'b00, h_cnt} < h_b3) h_seg = SEG_SYNC;

    v_seg = SEG_BP;
    if ({2'b00, v_cnt} < v_b1)      v_seg = SEG_ACTIVE;
    else if ({2'b00, v_cnt} < v_b2) v_seg = SEG_FP;
    else if ({2'b00, v_cnt} < v_b3) v_seg = SEG_SYNC;

    h_wrap     = ({2'b00, h_cnt} == (h_tot - HS'(1)));
    v_wrap     = ({2'b00, v_cnt} == (v_tot - VS'(1)));
    frame_wrap = h_wrap && v_wrap;
  end

  assign h_state = h_seg;
  assign v_state = v_seg;

  // Pixel and line counters; the line counter steps when the pixel counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  // Registered decode of the current counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HPOL;
      vsync       <= ~VPOL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      hsync       <= (h_seg == SEG_SYNC) ? hpol_r : ~hpol_r;
      vsync       <= (v_seg == SEG_SYNC) ? vpol_r : ~vpol_r;
      de          <= (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Timing configuration: capture into pending, swap in at the frame edge.
  // A load on the frame-edge cycle applies the older pending set and keeps
  // the new one staged for the following frame edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_act_r     <= fix_h(H_W'(H_ACT));
      h_fp_r      <= fix_h(H_W'(H_FP));
      h_sync_r    <= fix_h(H_W'(H_SYNC));
      h_bp_r      <= fix_h(H_W'(H_BP));
      v_act_r     <= fix_v(V_W'(V_ACT));
      v_fp_r      <= fix_v(V_W'(V_FP));
      v_sync_r    <= fix_v(V_W'(V_SYNC));
      v_bp_r      <= fix_v(V_W'(V_BP));
      hpol_r      <= HPOL;
      vpol_r      <= VPOL;
      p_h_act     <= fix_h(H_W'(H_ACT));
      p_h_fp      <= fix_h(H_W'(H_FP));
      p_h_sync    <= fix_h(H_W'(H_SYNC));
      p_h_bp      <= fix_h(H_W'(H_BP));
      p_v_act     <= fix_v(V_W'(V_ACT));
      p_v_fp      <= fix_v(V_W'(V_FP));
      p_v_sync    <= fix_v(V_W'(V_SYNC));
      p_v_bp      <= fix_v(V_W'(V_BP));
      p_hpol      <= HPOL;
      p_vpol      <= VPOL;
      cfg_pending <= 1'b0;
    end else begin
      if (enable && frame_wrap && cfg_pending) begin
        h_act_r  <= p_h_act;
        h_fp_r   <= p_h_fp;
        h_sync_r <= p_h_sync;
        h_bp_r   <= p_h_bp;
        v_act_r  <= p_v_act;
        v_fp_r   <= p_v_fp;
        v_sync_r <= p_v_sync;
        v_bp_r   <= p_v_bp;
        hpol_r   <= p_hpol;
        vpol_r   <= p_vpol;
      end
      if (cfg_load) begin
        p_h_act     <= fix_h(cfg_h_act);
        p_h_fp      <= fix_h(cfg_h_fp);
        p_h_sync    <= fix_h(cfg_h_sync);
        p_h_bp      <= fix_h(cfg_h_bp);
        p_v_act     <= fix_v(cfg_v_act);
        p_v_fp      <= fix_v(cfg_v_fp);
        p_v_sync    <= fix_v(cfg_v_sync);
        p_v_bp      <= fix_v(cfg_v_bp);
        p_hpol      <= cfg_hpol;
        p_vpol      <= cfg_vpol;
        cfg_pending <= 1'b1;
      end else if (enable && frame_wrap) begin
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a driver issues one cycle per call and pushes
// the expected output vector and cfg_pending value; a monitor on the
// falling edge pops and compares. Window tasks compare per-frame totals
// against hand-computed counts.
module tb_vga_timing_gen;

  localparam int H_W = 12;
  localparam int V_W = 11;
  // Small power-on timing: h 5/1/1/1 (8), v 2/1/1/1 (5), both polarities low.
  localparam int P_H[4] = '{5, 1, 1, 1};
  localparam int P_V[4] = '{2, 1, 1, 1};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           enable = 1'b0;
  logic [H_W-1:0] cfg_h_act = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
  logic [V_W-1:0] cfg_v_act = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
  logic           cfg_hpol = 1'b0, cfg_vpol = 1'b0, cfg_load = 1'b0;
  logic           cfg_pending, hsync, vsync, de, line_start, frame_start;
  logic [H_W-1:0] x;
  logic [V_W-1:0] y;
  logic [1:0]     h_state, v_state;

  vga_timing_gen #(
    .H_W(H_W), .V_W(V_W),
    .H_ACT(5), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACT(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HPOL(1'b0), .VPOL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .h_state(h_state), .v_state(v_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [27:0] exp_q[$];
  logic        pend_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  int mh[4], mv[4], ph[4], pv[4], ch[4], cv[4];
  bit mhp, mvp, php, pvp, chp, cvp, mpend;
  int mx, my;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mh[i] = P_H[i]; mv[i] = P_V[i]; ph[i] = P_H[i]; pv[i] = P_V[i];
    end
    mhp = 0; mvp = 0; php = 0; pvp = 0; mpend = 0; mx = 0; my = 0;
  endfunction

  function automatic logic [27:0] model_out();
    int h1, h2, v1, v2;
    bit hs, vs, d, ls, fs;
    h1 = mh[0] + mh[1]; h2 = h1 + mh[2];
    v1 = mv[0] + mv[1]; v2 = v1 + mv[2];
    hs = (mx >= h1 && mx < h2) ? mhp : ~mhp;
    vs = (my >= v1 && my < v2) ? mvp : ~mvp;
    d  = (mx < mh[0]) && (my < mv[0]);
    ls = (mx == 0);
    fs = (mx == 0) && (my == 0);
    return {hs, vs, d, ls, fs, 12'(mx), 11'(my)};
  endfunction

  // Advances one pixel; returns 1 on the last pixel of the frame.
  function automatic bit model_step();
    int ht, vt;
    bit fw;
    ht = mh[0] + mh[1] + mh[2] + mh[3];
    vt = mv[0] + mv[1] + mv[2] + mv[3];
    fw = (mx == ht - 1) && (my == vt - 1);
    if (mx == ht - 1) begin
      mx = 0;
      my = (my == vt - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    return fw;
  endfunction

  // ---------------- driver ----------------
  logic drv_active = 1'b0;

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    ch = '{ha, hf, hs, hb}; cv = '{va, vf, vs, vb}; chp = hp; cvp = vp;
    cfg_h_act = H_W'(ha); cfg_h_fp = H_W'(hf); cfg_h_sync = H_W'(hs); cfg_h_bp = H_W'(hb);
    cfg_v_act = V_W'(va); cfg_v_fp = V_W'(vf); cfg_v_sync = V_W'(vs); cfg_v_bp = V_W'(vb);
    cfg_hpol = hp; cfg_vpol = vp;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic do_cycle(input bit en, input bit r, input bit ld);
    bit fw;
    enable = en; rst = r; cfg_load = ld; drv_active = 1'b1;
    if (r) begin
      model_reset();
    end else begin
      fw = 0;
      if (en) begin
        exp_q.push_back(model_out());
        fw = model_step();
        if (fw && mpend) begin
          mh = ph; mv = pv; mhp = php; mvp = pvp;
        end
      end
      if (ld) begin
        for (int i = 0; i < 4; i++) begin
          ph[i] = (ch[i] == 0) ? 1 : ch[i];
          pv[i] = (cv[i] == 0) ? 1 : cv[i];
        end
        php = chp; pvp = cvp; mpend = 1;
      end else if (fw) begin
        mpend = 0;
      end
    end
    pend_q.push_back(mpend);
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int tx, input int ty);
    int guard = 0;
    while (!(mx == tx && my == ty) && guard < 1000) begin
      do_cycle(1, 0, 0);
      guard++;
    end
    check("run_to_reached", {16'(mx), 16'(my)}, {16'(tx), 16'(ty)});
  endtask

  // ---------------- monitor ----------------
  logic issued_q = 1'b0, en_q = 1'b0, rst_q = 1'b0;
  logic [27:0] last_exp = '0;
  int st_de = 0, st_hs = 0, st_vs = 0, st_ls = 0, st_fs = 0;
  localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 3'b000, 12'd0, 11'd0};

  always @(posedge clk) begin
    issued_q <= drv_active;
    en_q     <= enable;
    rst_q    <= rst;
  end

  always @(negedge clk) begin
    logic [27:0] cur, e;
    if (issued_q) begin
      if (pend_q.size() == 0) begin
        n_checks++;
        $display("FAIL pend_q_empty: got none expected entry");
      end else begin
        check("cfg_pending", {31'd0, cfg_pending}, {31'd0, pend_q.pop_front()});
      end
      cur = {hsync, vsync, de, line_start, frame_start, x, y};
      if (rst_q) begin
        check("reset_out", {4'd0, cur}, {4'd0, RST_VEC});
        last_exp = RST_VEC;
      end else if (en_q) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL exp_q_empty: got %h expected entry", cur);
        end else begin
          e = exp_q.pop_front();
          check("pixel_out", {4'd0, cur}, {4'd0, e});
          last_exp = e;
        end
        st_de += int'(de); st_hs += int'(hsync); st_vs += int'(vsync);
        st_ls += int'(line_start); st_fs += int'(frame_start);
      end else begin
        check("hold_out", {4'd0, cur}, {4'd0, last_exp});
      end
    end
  end

  // Runs n enabled cycles and compares high-cycle totals against hand counts.
  task automatic window(input string tag, input int n, input int e_de, e_hs, e_vs, e_ls, e_fs);
    int b_de, b_hs, b_vs, b_ls, b_fs;
    b_de = st_de; b_hs = st_hs; b_vs = st_vs; b_ls = st_ls; b_fs = st_fs;
    for (int i = 0; i < n; i++) do_cycle(1, 0, 0);
    check({tag, "_de"}, st_de - b_de, e_de);
    check({tag, "_hsync"}, st_hs - b_hs, e_hs);
    check({tag, "_vsync"}, st_vs - b_vs, e_vs);
    check({tag, "_line_start"}, st_ls - b_ls, e_ls);
    check({tag, "_frame_start"}, st_fs - b_fs, e_fs);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 0);
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 0);

    // Power-on timing: 8x5 frame, pol low.
    window("param", 40, 10, 35, 32, 5, 1);

    // h 4/1/2/1, v 3/1/1/1, pol high, loaded mid-frame.
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
    run_to(2, 1);
    do_cycle(1, 0, 1);
    run_to(0, 0);
    window("cfg48", 48, 12, 12, 8, 6, 1);

    // Same timing at half rate.
    for (int i = 0; i < 96; i++) do_cycle((i % 2) == 0, 0, 0);

    // Line length 10 loaded at y=1.
    set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1, 1);
    run_to(0, 1);
    do_cycle(1, 0, 1);
    run_to(0, 0);
    window("cfg60", 60, 18, 12, 10, 6, 1);

    // Load A mid-frame, then B on the frame-edge cycle itself.
    set_cfg(5, 1, 1, 1, 3, 1, 1, 1, 1, 1);
    run_to(3, 2);
    do_cycle(1, 0, 1);
    set_cfg(4, 0, 2, 1, 3, 1, 1, 1, 0, 0);
    run_to(9, 5);
    do_cycle(1, 0, 1);
    window("cfgA", 48, 15, 6, 8, 6, 1);
    // B: zero front porch becomes 1, pol low.
    window("cfgB", 48, 12, 36, 40, 6, 1);

    // Reset mid-frame with a pending configuration.
    set_cfg(7, 1, 1, 1, 4, 1, 1, 1, 1, 1);
    run_to(1, 0);
    do_cycle(1, 0, 1);
    run_to(3, 2);
    do_cycle(1, 1, 0);
    do_cycle(0, 1, 0);
    do_cycle(0, 0, 0);
    window("post_rst", 40, 10, 35, 32, 5, 1);

    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_W, default 12, width of horizontal counter, segment lengths and x.
REQ-002 SHALL have parameter V_W, default 11, width of vertical counter, segment lengths and y.
REQ-003 SHALL have parameters H_ACT/H_FP/H_SYNC/H_BP, default 640/16/96/48, reset horizontal segment lengths.
REQ-004 SHALL have parameters V_ACT/V_FP/V_SYNC/V_BP, default 480/10/2/33, reset vertical segment lengths.
REQ-005 SHALL have parameters HPOL/VPOL, default 0/0, reset sync polarity (1 = active-high).
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 enable  in  1  pixel-clock enable; counters and outputs update only when high.
REQ-009 cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  H_W each  new horizontal segment lengths.
REQ-010 cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  V_W each  new vertical segment lengths.
REQ-011 cfg_hpol, cfg_vpol  in  1 each  new sync polarities.
REQ-012 cfg_load  in  1  capture all cfg_* into pending registers.
REQ-013 cfg_pending  out  1  pending configuration not yet applied.
REQ-014 hsync, vsync  out  1 each  sync outputs at programmed polarity.
REQ-015 de  out  1  data enable: horizontal and vertical both active.
REQ-016 x  out  H_W  pixel column; y  out  V_W  line number.
REQ-017 line_start  out  1  pulse on first pixel of every line; frame_start  out  1  pulse on pixel (0,0).

Function
REQ-018 Each axis SHALL sequence ACTIVE -> FRONTPORCH -> SYNC -> BACKPORCH -> ACTIVE; counter runs 0..total-1, total = act+fp+sync+bp.
REQ-019 Horizontal counter SHALL advance on every enable cycle, wrapping to 0 after total-1.
REQ-020 Vertical counter SHALL advance only on enable cycles where horizontal counter wraps; wraps to 0 after total-1.
REQ-021 On each enable cycle outputs SHALL register decode of current counters, then counters advance: 1-cycle latency, all outputs mutually aligned.
REQ-022 hsync SHALL be at active level (pol=1 -> 1, pol=0 -> 0) while horizontal state is SYNC, else inverse; vsync likewise from vertical state.
REQ-023 de SHALL be 1 only when both axes in ACTIVE.
REQ-024 x SHALL equal horizontal counter and y vertical counter, outside active region too.
REQ-025 line_start SHALL be 1 when horizontal counter = 0; frame_start SHALL be 1 when both counters = 0.
REQ-026 When enable is low, counters, state and all outputs SHALL hold.
REQ-027 cfg_load=1 SHALL capture cfg_* into pending registers and set cfg_pending on the next cycle, regardless of enable.
REQ-028 Pending values SHALL transfer to active timing on the enable cycle where both counters wrap (last pixel of frame); cfg_pending clears the same cycle.
REQ-029 cfg_load coinciding with frame wrap SHALL capture new values, apply previous pending (if any), and leave cfg_pending=1 for the next frame boundary.
REQ-030 Repeated cfg_load before a boundary SHALL overwrite pending; last load wins.
REQ-031 Any segment length input of 0 SHALL be stored as 1.
REQ-032 Segment sums SHALL be computed in W+2 bits; configurations with total > 2^W are unsupported and need not be detected.

Reset
REQ-033 rst SHALL load active and pending timing from parameters, clear counters to 0, clear cfg_pending.
REQ-034 During/after rst, before first enable: de=0, x=0, y=0, line_start=0, frame_start=0, hsync=!HPOL, vsync=!VPOL.
REQ-035 rst mid-frame SHALL discard pending configuration; first enable after reset outputs pixel (0,0) with frame_start=1.

Verification
REQ-036 Cfg h 4/1/2/1, v 3/1/1/1, pol 1/1, applied via load+frame wrap, enable always high -> frame of 48 cycles; de high 12 cycles; hsync high x=5..6 each line; vsync high y=4 for 8 cycles.
REQ-037 Same cfg, enable toggling 1/0 -> identical output sequence at half rate, outputs held on enable-low cycles.
REQ-038 cfg_load at y=1 with h_act=6 -> cfg_pending=1 until wrap; new line length 10 starts at next frame_start, previous frame unaffected.
REQ-039 cfg_load on exact frame-wrap cycle -> cfg_pending stays 1; values take effect one frame later.
REQ-040 cfg with h_fp=0 and pol 0 -> fp treated as 1 (total 8); hsync low during SYNC, high otherwise.
REQ-041 rst asserted at x=3,y=2 with pending cfg -> outputs reset per REQ-034, parameter timing resumes, cfg_pending=0.
